fpga_bootrom_arbiter: RTL and testbench
=======================================

Name: fpga_bootrom_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port FPGA bootrom (active-low CEN, registered address, Q valid the cycle after enable).
- Shares the ROM between the core instruction-fetch port and a data/debug port using a req/gnt/rvalid protocol.
- Converts byte addresses to ROM word indices.
- Arbitrates round-robin and returns read data one cycle after grant.

Parameters:
- ROM_ADDR_WIDTH, 10, ROM word-index width driven to the bootrom A input.
- DATA_WIDTH, 32, data width of ROM Q and both rdata ports.
- BASE_ADDR, 32'h1A000000, byte base address of the ROM window.
- ROM_WORDS, 3, number of populated ROM words; used only by the optional error check.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- instr_req_i  in  1  instruction port request.
- instr_addr_i  in  32  instruction port byte address.
- instr_gnt_o  out  1  instruction port grant (combinational).
- instr_rvalid_o  out  1  instruction port read data valid.
- instr_rdata_o  out  DATA_WIDTH  instruction port read data.
- instr_err_o  out  1  instruction port error response.
- data_req_i  in  1  data port request.
- data_addr_i  in  32  data port byte address.
- data_gnt_o  out  1  data port grant (combinational).
- data_rvalid_o  out  1  data port read data valid.
- data_rdata_o  out  DATA_WIDTH  data port read data.
- data_err_o  out  1  data port error response.
- rom_cen_o  out  1  bootrom chip enable, active low.
- rom_a_o  out  ROM_ADDR_WIDTH  bootrom word index.
- rom_q_i  in  DATA_WIDTH  bootrom read data.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Outputs during and after reset:
  - all gnt = 0, all rvalid = 0, all err = 0, all rdata = 0;
  - rom_cen_o = 1, rom_a_o = 0.
- Reset state:
  - round-robin pointer last_grant = DATA, so instr wins the first contention;
  - response register = IDLE.
- Word index: (addr - BASE_ADDR) >> 2, truncated to ROM_ADDR_WIDTH bits; modulo wrap inside the ROM.
- Arbitration (combinational, same cycle as req):
  - at most one gnt per cycle;
  - single requester is granted immediately;
  - if both request, grant goes to the port not equal to last_grant;
  - last_grant updates only on a grant.
- Issue:
  - in the grant cycle, rom_cen_o = 0 and rom_a_o = the granted port's index;
  - in cycles without a grant, rom_cen_o = 1 and rom_a_o = 0.
- Response state machine, states IDLE / RESP_I / RESP_D:
  - a grant moves it to RESP_I or RESP_D for exactly the next cycle;
  - no grant returns it to IDLE.
- Response cycle:
  - granted port sees rvalid = 1 and rdata = rom_q_i;
  - the other port sees rdata = 0;
  - rdata is 0 whenever rvalid = 0.
- Latency: gnt at cycle N gives rvalid at N+1. Throughput is one access per cycle; a new grant may coincide with the previous rvalid.
- No backpressure: requesters must accept rvalid.
- Requester rules:
  - hold req and addr stable until gnt;
  - withdrawing req before gnt is legal and leaves no state change.
- Reset mid-operation: a pending response is dropped; no rvalid appears in the cycle after reset deassertion.

Optional Feature:
Macro FPGA_BOOTROM_ARB_ERR_EN.
- Defined:
  - A granted access is illegal if addr[1:0] != 0, addr < BASE_ADDR, or word index >= ROM_WORDS (index computed before truncation).
  - An illegal access is granted normally, but rom_cen_o stays 1 and rom_a_o = 0 that cycle.
  - The next cycle gives rvalid = 1, err = 1, rdata = 0.
  - Arbitration and last_grant update are unchanged.
- Undefined:
  - err outputs are tied 0;
  - every address accesses the ROM using the truncated index.

Test Plan:
- Reset: RST = 1 for 3 cycles with both req high -> no gnt, rom_cen_o = 1, rvalid = 0. First post-reset contention grants instr.
- Single fetch: instr_req with addr 0x1A000004 -> instr_gnt same cycle, rom_cen_o = 0, rom_a_o = 1. Next cycle instr_rvalid = 1, instr_rdata = ROM word 1.
- Contention: both req held 4 cycles, addrs 0x1A000000 / 0x1A000008 -> grants alternate I, D, I, D; rvalid matches each grant one cycle later; data_rdata = word 2.
- Back-to-back: data_req held 3 cycles, addrs 0, 4, 8 (offset) -> data_rvalid high 3 consecutive cycles with words 0, 1, 2.
- Reset mid-op: grant at N, RST at N+1 -> no rvalid at N+1 or N+2.
- With FPGA_BOOTROM_ARB_ERR_EN: addr 0x1A000002 and 0x1A00000C -> gnt, rom_cen_o = 1, next cycle err = 1, rdata = 0. Without the macro, 0x1A00000C reads index 3 with err = 0.

Source files
------------

// File: rtl/fpga_bootrom_arbiter.sv
// Two-port round-robin arbiter in front of the single-port FPGA bootrom; read data returns one cycle after grant.
// Define FPGA_BOOTROM_ARB_ERR_EN to reject misaligned or out-of-window accesses with an error response.
module fpga_bootrom_arbiter #(
  parameter int unsigned ROM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
  parameter int unsigned ROM_WORDS      = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  output logic                      instr_err_o,
  input  logic                      data_req_i,
  input  logic [31:0]               data_addr_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      data_err_o,
  output logic                      rom_cen_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_a_o,
  input  logic [DATA_WIDTH-1:0]     rom_q_i
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} resp_state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} port_t;

  resp_state_t               resp_state;
  port_t                     last_grant;
  logic                      resp_err;
  logic                      instr_gnt;
  logic                      data_gnt;
  logic                      any_gnt;
  logic                      acc_illegal;
  logic                      rom_access;
  logic [31:0]               sel_addr;
  logic [ROM_ADDR_WIDTH-1:0] sel_index;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    instr_gnt = ~RST & instr_req_i & (~data_req_i | (last_grant == GRANT_DATA));
    data_gnt  = ~RST & data_req_i & (~instr_req_i | (last_grant == GRANT_INSTR));
    any_gnt   = instr_gnt | data_gnt;
    sel_addr  = data_gnt ? data_addr_i : instr_addr_i;
    sel_index = ROM_ADDR_WIDTH'((sel_addr - BASE_ADDR) >> 2);
  end

`ifdef FPGA_BOOTROM_ARB_ERR_EN
  logic [31:0] word_full;

  // The range check uses the untruncated word index so aliases above the ROM are rejected.
  always_comb begin
    word_full   = (sel_addr - BASE_ADDR) >> 2;
    acc_illegal = (sel_addr[1:0] != 2'b00) | (sel_addr < BASE_ADDR) | (word_full >= ROM_WORDS);
  end
`else
  assign acc_illegal = 1'b0;
`endif

  always_comb begin
    rom_access = any_gnt & ~acc_illegal;
    rom_cen_o  = ~rom_access;
    rom_a_o    = rom_access ? sel_index : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_state <= IDLE;
      last_grant <= GRANT_DATA;
      resp_err   <= 1'b0;
    end else begin
      resp_err <= any_gnt & acc_illegal;
      if (instr_gnt) begin
        resp_state <= RESP_I;
        last_grant <= GRANT_INSTR;
      end else if (data_gnt) begin
        resp_state <= RESP_D;
        last_grant <= GRANT_DATA;
      end else begin
        resp_state <= IDLE;
      end
    end
  end

  // Responses are masked while RST is high so a pending read is dropped immediately.
  always_comb begin
    instr_gnt_o    = instr_gnt;
    data_gnt_o     = data_gnt;
    instr_rvalid_o = ~RST & (resp_state == RESP_I);
    data_rvalid_o  = ~RST & (resp_state == RESP_D);
    instr_rdata_o  = (instr_rvalid_o & ~resp_err) ? rom_q_i : '0;
    data_rdata_o   = (data_rvalid_o & ~resp_err) ? rom_q_i : '0;
    instr_err_o    = instr_rvalid_o & resp_err;
    data_err_o     = data_rvalid_o & resp_err;
  end

endmodule

// File: tb/tb_fpga_bootrom_arbiter.sv
// Randomized bench for fpga_bootrom_arbiter against a cycle-level reference model and a registered bootrom model.
module tb_fpga_bootrom_arbiter;

  localparam logic [31:0] BASE = 32'h1A00_0000;
  localparam int unsigned NWORDS = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        rom_cen_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q_i = '0;

  fpga_bootrom_arbiter dut (
    .CLK(CLK), .RST(RST),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .rom_cen_o(rom_cen_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i)
  );

  always #5 CLK = ~CLK;

  logic [31:0] rom_mem [1024];

  // Bootrom model: Q updates on the clock edge that samples an active-low enable.
  always @(posedge CLK) begin
    if (!rom_cen_o) rom_q_i <= rom_mem[rom_a_o];
  end

  int checks = 0;
  int errors = 0;

  bit          m_last_data = 1'b1;
  int          m_pend = 0;
  bit          m_pend_err = 1'b0;
  logic [31:0] m_pend_data = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit addrLegal(input logic [31:0] a);
`ifdef FPGA_BOOTROM_ARB_ERR_EN
    return (a % 4 == 0) && (a >= BASE) && (((a - BASE) / 4) < NWORDS);
`else
    return 1'b1;
`endif
  endfunction

  task automatic applyStimulus(input bit rst, input bit ireq, input logic [31:0] iaddr,
                               input bit dreq, input logic [31:0] daddr);
    bit          eig, edg, acc;
    logic [31:0] gaddr;
    int          idx;
    bit          eiv, edv;
    @(posedge CLK);
    #1;
    RST = rst;
    instr_req_i = ireq;
    instr_addr_i = iaddr;
    data_req_i = dreq;
    data_addr_i = daddr;
    #4;
    eig = !rst && ireq && (!dreq || m_last_data);
    edg = !rst && dreq && (!ireq || !m_last_data);
    gaddr = edg ? daddr : iaddr;
    acc = (eig || edg) && addrLegal(gaddr);
    idx = int'(((gaddr - BASE) / 4) % 1024);
    eiv = !rst && (m_pend == 1);
    edv = !rst && (m_pend == 2);
    checkOutput("instr_gnt", instr_gnt_o, eig);
    checkOutput("data_gnt", data_gnt_o, edg);
    checkOutput("rom_cen", rom_cen_o, !acc);
    checkOutput("rom_a", rom_a_o, acc ? idx : 0);
    checkOutput("instr_rvalid", instr_rvalid_o, eiv);
    checkOutput("data_rvalid", data_rvalid_o, edv);
    checkOutput("instr_rdata", instr_rdata_o, (eiv && !m_pend_err) ? m_pend_data : 32'h0);
    checkOutput("data_rdata", data_rdata_o, (edv && !m_pend_err) ? m_pend_data : 32'h0);
    checkOutput("instr_err", instr_err_o, eiv && m_pend_err);
    checkOutput("data_err", data_err_o, edv && m_pend_err);
    if (rst) begin
      m_last_data = 1'b1;
      m_pend = 0;
    end else if (eig || edg) begin
      m_pend = eig ? 1 : 2;
      m_last_data = edg;
      m_pend_err = !addrLegal(gaddr);
      m_pend_data = rom_mem[idx];
    end else begin
      m_pend = 0;
    end
  endtask

  function automatic logic [31:0] randAddr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return BASE + 32'($urandom_range(0, 5)) * 4;
    if (sel == 6) return BASE + 32'($urandom_range(0, 15));
    if (sel == 7) return BASE - 32'($urandom_range(1, 64));
    if (sel == 8) return BASE + 32'($urandom_range(0, 8191));
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, BASE, 1, BASE + 8);

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, BASE, 1, BASE + 8);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(0, 1, BASE + 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, BASE + 32'(i * 4));
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(0, 1, BASE + 8, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(0, 1, BASE + 2, 0, 0);
    applyStimulus(0, 0, 0, 1, BASE + 12);
    applyStimulus(0, 1, BASE - 4, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, randAddr(),
                    $urandom_range(0, 2) != 0, randAddr());
    end
    applyStimulus(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
